// File: rtl/pipe_dmem_resp.sv
// Data-memory responder: posted store buffer in front of a single-port word RAM, load forwarding.
// Latency: loads return combinationally the same cycle; stores retire to RAM >=1 cycle after push.
// Backpressure: mem_stall for one cycle when a store meets a full buffer; a drain is forced that cycle.
module pipe_dmem_resp #(
    parameter int ADDR_W   = 10,
    parameter int SB_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        mwmem,
    input  logic                        mm2reg,
    input  logic [31:0]                 malu,
    input  logic [31:0]                 mb,
    output logic [31:0]                 mmo,
    output logic                        mem_stall,
    output logic                        sb_empty,
    output logic [$clog2(SB_DEPTH):0]   sb_count
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] sb_idx [SB_DEPTH];
    logic [31:0]       sb_dat [SB_DEPTH];
    logic [31:0]       ram    [0:(1<<ADDR_W)-1];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic [ADDR_W-1:0] idx;
    logic              full;
    logic              push;
    logic              drain;
    logic              hit;
    logic [31:0]       fwd_dat;
    logic [PW-1:0]     pos;
    logic              unused_addr_bits;

    assign idx              = malu[ADDR_W+1:2];
    assign unused_addr_bits = ^{malu[31:ADDR_W+2], malu[1:0]};

    assign full      = (count == CW'(SB_DEPTH));
    assign push      = mwmem && !full;
    assign mem_stall = mwmem && full;

    // Scan oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        hit     = 1'b0;
        fwd_dat = '0;
        pos     = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = head + PW'(i);
            if ((CW'(i) < count) && (sb_idx[pos] == idx)) begin
                hit     = 1'b1;
                fwd_dat = sb_dat[pos];
            end
        end
    end

    // A missing load owns the RAM port; a stalled store forces a drain so the retry always fits.
    assign drain = (count != '0) && (!mm2reg || hit || mem_stall);

    always_comb begin
        mmo = '0;
        if (resetn && mm2reg && !mwmem)
            mmo = hit ? fwd_dat : ram[idx];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            sb_idx[tail] <= idx;
            sb_dat[tail] <= mb;
        end
        if (drain)
            ram[sb_idx[head]] <= sb_dat[head];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (drain)
                head <= head + 1'b1;
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign sb_empty = (count == '0);
    assign sb_count = count;

endmodule

// File: tb/tb_pipe_dmem_resp.sv
// Directed bench for pipe_dmem_resp; load results are checked by a queue-driven monitor.
module tb_pipe_dmem_resp;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        mwmem  = 1'b0;
    logic        mm2reg = 1'b0;
    logic [31:0] malu   = '0;
    logic [31:0] mb     = '0;
    logic [31:0] mmo;
    logic        mem_stall;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q  [$];
    string       name_q [$];
    logic        last_stall = 1'b0;

    always #5 clock = ~clock;

    pipe_dmem_resp #(.ADDR_W(10), .SB_DEPTH(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwmem     (mwmem),
        .mm2reg    (mm2reg),
        .malu      (malu),
        .mb        (mb),
        .mmo       (mmo),
        .mem_stall (mem_stall),
        .sb_empty  (sb_empty),
        .sb_count  (sb_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every load cycle pops one expectation; non-load cycles must read zero.
    always @(negedge clock) begin
        if (resetn) begin
            if (mm2reg) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_load: got mmo %h want no load", mmo);
                end else begin
                    check(name_q.pop_front(), mmo, exp_q.pop_front());
                end
            end else begin
                check("mmo_idle", mmo, 32'h0);
            end
        end
    end

    // Drives one cycle starting at posedge+1, returns at the next posedge+1.
    task automatic step(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] dat, input logic [31:0] exp, input string nm);
        mwmem  = we;
        mm2reg = re;
        malu   = addr;
        mb     = dat;
        if (re) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        if (we && re)
            $display("note: illegal store+load issued at %h", addr);
        @(negedge clock);
        last_stall = mem_stall;
        @(posedge clock);
        #1;
        mwmem  = 1'b0;
        mm2reg = 1'b0;
        malu   = '0;
        mb     = '0;
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] dat);
        step(1'b1, 1'b0, addr, dat, 32'h0, "");
    endtask

    task automatic ld(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        step(1'b0, 1'b1, addr, 32'h0, exp, nm);
    endtask

    // Store with a simultaneous load to the same (missing) word: blocks the drain, mmo reads zero.
    task automatic stld(input logic [31:0] addr, input logic [31:0] dat);
        step(1'b1, 1'b1, addr, dat, 32'h0, "illegal_mmo_zero");
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check("rst_sb_empty",  sb_empty,  1);
        check("rst_sb_count",  sb_count,  0);
        check("rst_mem_stall", mem_stall, 0);
        check("rst_mmo",       mmo,       0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // 1: single store drains on the next idle cycle
        st(32'h10, 32'h1111_0000);
        check("t1_stall",       last_stall, 0);
        check("t1_count_store", sb_count,   1);
        idle();
        check("t1_count_idle",  sb_count,   0);
        check("t1_empty_idle",  sb_empty,   1);
        ld(32'h10, 32'h1111_0000, "t1_ram_load");

        // 2: youngest-hit forwarding, older store still reaches RAM first
        st(32'h20, 32'hA);
        st(32'h20, 32'hB);
        check("t2_count", sb_count, 1);
        ld(32'h20, 32'hB, "t2_fwd_youngest");
        check("t2_count_after_hit", sb_count, 0);
        idle();
        ld(32'h20, 32'hB, "t2_ram_after_drain");

        // 3: fill, one-cycle stall on the fifth store, retry accepted
        for (int i = 0; i < 4; i++)
            stld(32'h40 + 32'(4 * i), 32'(i + 1));
        check("t3_count_full", sb_count, 4);
        st(32'h50, 32'h5);
        check("t3_stall_full",  last_stall, 1);
        check("t3_count_stall", sb_count,   3);
        st(32'h50, 32'h5);
        check("t3_stall_retry", last_stall, 0);
        check("t3_count_retry", sb_count,   3);
        idle();
        idle();
        idle();
        check("t3_count_drained", sb_count, 0);
        for (int i = 0; i < 5; i++)
            ld(32'h40 + 32'(4 * i), 32'(i + 1), $sformatf("t3_ram_%0d", i));

        // 4: address bits above the word index alias to the same word
        st(32'h4, 32'hCAFE_0004);
        ld(32'h1004, 32'hCAFE_0004, "t4_alias_fwd");
        check("t4_count", sb_count, 0);
        ld(32'h1004, 32'hCAFE_0004, "t4_alias_ram");
        ld(32'h0004, 32'hCAFE_0004, "t4_ram_direct");

        // 5: async reset discards buffered stores
        for (int i = 0; i < 3; i++) begin
            st(32'h60 + 32'(4 * i), 32'hAAAA_0000 + 32'(i));
            idle();
        end
        for (int i = 0; i < 3; i++)
            stld(32'h60 + 32'(4 * i), 32'h5555_0000 + 32'(i));
        check("t5_count_before_rst", sb_count, 3);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_empty_async", sb_empty, 1);
        check("t5_count_async", sb_count, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        st(32'h6C, 32'h6C6C_6C6C);
        check("t5_stall_after_rst", last_stall, 0);
        check("t5_count_after_rst", sb_count,   1);
        idle();
        for (int i = 0; i < 3; i++)
            ld(32'h60 + 32'(4 * i), 32'hAAAA_0000 + 32'(i), $sformatf("t5_old_ram_%0d", i));
        ld(32'h6C, 32'h6C6C_6C6C, "t5_new_store");

        // 6: drains only on hit cycles
        stld(32'h70, 32'h70);
        stld(32'h74, 32'h74);
        check("t6_count_2", sb_count, 2);
        ld(32'h74, 32'h74, "t6_hit1");
        check("t6_count_after_hit1", sb_count, 1);
        ld(32'h10, 32'h1111_0000, "t6_miss");
        check("t6_count_after_miss", sb_count, 1);
        ld(32'h74, 32'h74, "t6_hit2");
        check("t6_count_after_hit2", sb_count, 0);
        ld(32'h70, 32'h70, "t6_ram70");
        ld(32'h74, 32'h74, "t6_ram74");

        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_loads: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
